// File: rtl/shift_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : shift_exec_stage
// Description : Registered execute stage around a 16-bit SLL/SRA/ROR shifter
//               with valid/ready handshake and an architectural Z flag.
//               Define SHIFT_SKID_EN for a 1-entry skid buffer.
// Revision    : 1.0  initial release
// ============================================================================
module shift_exec_stage #(
  parameter int DATA_W = 16,
  parameter int DST_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [3:0]        in_amt,
  input  logic [1:0]        in_mode,
  input  logic [DST_W-1:0]  in_dst,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DST_W-1:0]  out_dst,
  output logic              z_flag
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_out_result;
  logic [DST_W-1:0]  r_out_dst;
  logic              r_z_flag;
  logic [DATA_W-1:0] w_shift_res;
  logic              w_accept;
  logic              w_retire;
  logic              w_load_out;
`ifdef SHIFT_SKID_EN
  logic [DATA_W-1:0] r_skid_result;
  logic [DST_W-1:0]  r_skid_dst;
  logic              w_load_skid;
  logic              w_skid_to_out;
`endif

  // Shifter: mode 11 is reserved and behaves as ROR.
  always_comb begin
    w_shift_res = in_data;
    unique case (in_mode)
      2'b00:   w_shift_res = in_data << in_amt;
      2'b01:   w_shift_res = DATA_W'($signed(in_data) >>> in_amt);
      default: w_shift_res = (in_data >> in_amt) | (in_data << (DATA_W - int'(in_amt)));
    endcase
  end

  assign out_valid = (r_state != S_EMPTY);
`ifdef SHIFT_SKID_EN
  assign in_ready  = (r_state != S_TWO);
`else
  assign in_ready  = !out_valid | out_ready;
`endif
  assign w_accept  = in_valid & in_ready & !flush;
  assign w_retire  = out_valid & out_ready & !flush;

  always_comb begin
    w_state_nxt   = r_state;
    w_load_out    = 1'b0;
`ifdef SHIFT_SKID_EN
    w_load_skid   = 1'b0;
    w_skid_to_out = 1'b0;
`endif
    unique case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_load_out  = 1'b1;
          w_state_nxt = S_ONE;
        end
      end
      S_ONE: begin
        if (w_accept && w_retire) begin
          w_load_out = 1'b1;
`ifdef SHIFT_SKID_EN
        end else if (w_accept) begin
          w_load_skid = 1'b1;
          w_state_nxt = S_TWO;
`endif
        end else if (w_retire) begin
          w_state_nxt = S_EMPTY;
        end
      end
`ifdef SHIFT_SKID_EN
      S_TWO: begin
        // Skid always drains into the output reg, preserving order.
        if (w_retire) begin
          w_skid_to_out = 1'b1;
          w_state_nxt   = S_ONE;
        end
      end
`endif
      default: w_state_nxt = S_EMPTY;
    endcase
    if (flush) w_state_nxt = S_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_EMPTY;
      r_out_result  <= '0;
      r_out_dst     <= '0;
      r_z_flag      <= 1'b0;
`ifdef SHIFT_SKID_EN
      r_skid_result <= '0;
      r_skid_dst    <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      if (w_retire) r_z_flag <= (r_out_result == '0);
      if (w_load_out) begin
        r_out_result <= w_shift_res;
        r_out_dst    <= in_dst;
      end
`ifdef SHIFT_SKID_EN
      if (w_load_skid) begin
        r_skid_result <= w_shift_res;
        r_skid_dst    <= in_dst;
      end
      if (w_skid_to_out) begin
        r_out_result <= r_skid_result;
        r_out_dst    <= r_skid_dst;
      end
`endif
    end
  end

  assign out_result = r_out_result;
  assign out_dst    = r_out_dst;
  assign z_flag     = r_z_flag;

endmodule
`default_nettype wire

// File: tb/tb_shift_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_exec_stage
// Description : Self-checking bench for shift_exec_stage using a queue model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_shift_exec_stage;

`ifdef SHIFT_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [3:0]  in_amt = '0;
  logic [1:0]  in_mode = '0;
  logic [3:0]  in_dst = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;
  logic [3:0]  out_dst;
  logic        z_flag;

  shift_exec_stage #(.DATA_W(16), .DST_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode), .in_dst(in_dst),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dst(out_dst), .z_flag(z_flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  dst;
  } op_t;

  op_t  q[$];
  logic mz = 1'b0;
  int   total = 0;
  int   bad = 0;

  function automatic logic [15:0] ref_shift(logic [15:0] d, logic [3:0] a, logic [1:0] m);
    logic [31:0] w;
    case (m)
      2'b00:   w = {16'h0000, d} << a;
      2'b01:   w = {{16{d[15]}}, d} >> a;
      default: w = {d, d} >> a;
    endcase
    return w[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_result", 32'(out_result), 32'(q[0].res));
      chk("out_dst", 32'(out_dst), 32'(q[0].dst));
    end
    chk("z_flag", 32'(z_flag), 32'(mz));
  endtask

  task automatic cyc(input logic iv, input logic [15:0] d, input logic [3:0] a,
                     input logic [1:0] m, input logic [3:0] ds,
                     input logic ordy, input logic fl);
    logic mrdy, acc, ret;
    @(negedge clk);
    in_valid = iv; in_data = d; in_amt = a; in_mode = m; in_dst = ds;
    out_ready = ordy; flush = fl;
    #1;
    mrdy = SKID ? (q.size() < 2) : (q.size() == 0 || ordy);
    chk("in_ready", 32'(in_ready), 32'(mrdy));
    acc = iv && mrdy && !fl;
    ret = (q.size() > 0) && ordy && !fl;
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
    end else begin
      if (ret) begin
        mz = (q[0].res == 16'h0000);
        void'(q.pop_front());
      end
      if (acc) q.push_back('{res: ref_shift(d, a, m), dst: ds});
    end
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    @(posedge clk);
    #1;
    q.delete();
    mz = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", 32'(out_result), 32'd0);
    chk("rst_out_dst", 32'(out_dst), 32'd0);
    chk("rst_z_flag", 32'(z_flag), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] d;

    do_reset();

    // Basic SLL, then retire with non-zero result.
    cyc(1'b1, 16'h0001, 4'd4, 2'b00, 4'd3, 1'b1, 1'b0);
    chk("sll_0001_4", 32'(out_result), 32'h0010);
    cyc(1'b0, 16'h0000, 4'd0, 2'b00, 4'd0, 1'b1, 1'b0);
    chk("sll_z", 32'(z_flag), 32'd0);

    // SRA, ROR, reserved mode back-to-back.
    cyc(1'b1, 16'h8000, 4'd15, 2'b01, 4'd1, 1'b1, 1'b0);
    chk("sra_8000_15", 32'(out_result), 32'hFFFF);
    cyc(1'b1, 16'h1234, 4'd8, 2'b10, 4'd2, 1'b1, 1'b0);
    chk("ror_1234_8", 32'(out_result), 32'h3412);
    cyc(1'b1, 16'h1234, 4'd4, 2'b11, 4'd4, 1'b1, 1'b0);
    chk("ror11_1234_4", 32'(out_result), 32'h4123);
    cyc(1'b1, 16'hBEEF, 4'd0, 2'b01, 4'd5, 1'b1, 1'b0);
    chk("amt0_pass", 32'(out_result), 32'hBEEF);
    cyc(1'b0, 16'h0000, 4'd0, 2'b00, 4'd0, 1'b1, 1'b0);

    // Zero result sets Z only on its retire edge.
    cyc(1'b1, 16'h8000, 4'd1, 2'b00, 4'd6, 1'b1, 1'b0);
    chk("zero_res", 32'(out_result), 32'h0000);
    chk("z_before_retire", 32'(z_flag), 32'd0);
    cyc(1'b0, 16'h0000, 4'd0, 2'b00, 4'd0, 1'b1, 1'b0);
    chk("z_after_retire", 32'(z_flag), 32'd1);

    // Backpressure ordering.
    cyc(1'b1, 16'h0001, 4'd1, 2'b00, 4'd7, 1'b0, 1'b0);
    cyc(1'b1, 16'h0001, 4'd2, 2'b00, 4'd8, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
    chk("stall_hold", 32'(out_result), 32'h0002);
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0000, 4'd0, 2'b00, 4'd0, 1'b1, 1'b0);

    // Flush with ops in flight and a same-cycle input.
    cyc(1'b1, 16'h0003, 4'd1, 2'b00, 4'd9, 1'b0, 1'b0);
    cyc(1'b1, 16'h0005, 4'd1, 2'b00, 4'd10, 1'b0, 1'b0);
    cyc(1'b1, 16'h0000, 4'd1, 2'b00, 4'd11, 1'b1, 1'b1);
    chk("flush_valid", 32'(out_valid), 32'd0);
    cyc(1'b0, 16'h0000, 4'd0, 2'b00, 4'd0, 1'b1, 1'b0);

    // Reset mid-stall, then resume.
    cyc(1'b1, 16'h00F0, 4'd2, 2'b00, 4'd12, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
    do_reset();
    cyc(1'b1, 16'h0003, 4'd1, 2'b01, 4'd13, 1'b1, 1'b0);
    chk("resume_sra", 32'(out_result), 32'h0001);
    cyc(1'b0, 16'h0000, 4'd0, 2'b00, 4'd0, 1'b1, 1'b0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      d = ($urandom % 6 == 0) ? 16'h0000 : 16'($urandom);
      if ($urandom % 120 == 0) begin
        do_reset();
      end else begin
        cyc(1'($urandom % 4 != 0), d, 4'($urandom), 2'($urandom), 4'($urandom),
            1'($urandom % 3 != 0), 1'($urandom % 30 == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
